alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 8-bit ALU. Accepts operation requests from two requesters with valid/ready handshakes, grants round-robin, holds the ALU's operand and op lines stable for the ALU's registered result cycle, and drives its output enable. It captures result and flags and returns them to the granted requester through a response handshake. It sits between the control units and the ALU and is the ALU's only driver.

---
 rtl/alu_arbiter_pkg.sv | 26 ++
 rtl/alu_arbiter_rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, flag bit positions and FSM states.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    localparam int FLAG_W = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to the
// port that was not granted last. Output grant is one-hot (or zero).
module alu_arbiter_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbiter/sequencer for the shared ALU: accepts one request at a time, holds
// operands through the ALU's registered result cycle and returns result + flags.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_flags,
    output logic              busy,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_en_out,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_flags
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                gnt_port_q, gnt_port_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic                alu_en_q, alu_en_d;
    logic                busy_q, busy_d;
    logic [1:0]          grant;
    logic [1:0]          req_ready;

    alu_arbiter_rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        gnt_port_d   = gnt_port_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready    = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    req_ready  = grant;
                    gnt_port_d = grant[1];
                    a_d        = grant[1] ? req1_a  : req0_a;
                    b_d        = grant[1] ? req1_b  : req0_b;
                    op_d       = grant[1] ? req1_op : req0_op;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            // Operands stay on the bus here: some flags are combinational on them.
            ST_CAPTURE: begin
                rsp_data_d  = alu_out;
                rsp_flags_d = alu_flags;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (gnt_port_q ? rsp1_ready : rsp0_ready) begin
                    last_grant_d = gnt_port_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        alu_en_d    = (state_d == ST_CAPTURE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = 2'b00;
        if (state_d == ST_RESP) begin
            rsp_valid_d = gnt_port_d ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            gnt_port_q   <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
            rsp_valid_q  <= 2'b00;
            alu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            gnt_port_q   <= gnt_port_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_valid_q  <= rsp_valid_d;
            alu_en_q     <= alu_en_d;
            busy_q       <= busy_d;
        end
    end

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = busy_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign alu_en_out = alu_en_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the bus, reference model of the
// expected grant/result per request, and a monitor scoreboard on the response side.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       busy;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic       alu_en_out;
    logic [7:0] alu_out;
    logic [3:0] alu_flags;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8), .OP_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_en_out(alu_en_out), .alu_out(alu_out), .alu_flags(alu_flags)
    );

    function automatic logic [7:0] alu_res(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_NOT:  return ~a;
            OP_CMP:  return a;
            OP_SHR:  return a >> 1;
            default: return a << 1;
        endcase
    endfunction

    function automatic logic [3:0] alu_flg(input logic [7:0] r, input logic [7:0] a,
                                           input logic [7:0] b, input logic [2:0] op);
        logic       c, o, z;
        logic [8:0] s;
        c = 1'b0;
        o = 1'b0;
        z = (r == 8'h00);
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                c = s[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                c = (a < b);
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_CMP: begin
                c = (a < b);
                z = (a == b);
            end
            OP_SHR:  c = a[0];
            OP_SHL:  c = a[7];
            default: c = 1'b0;
        endcase
        return {c, r[7], o, z};
    endfunction

    // ALU: result registered every cycle, flags live on current op/operands;
    // a disabled bus shows the inverted result instead of high-Z.
    logic [7:0] alu_res_q = 8'h00;
    always @(posedge clk) alu_res_q <= alu_res(alu_a, alu_b, alu_op);
    assign alu_out   = alu_en_out ? alu_res_q : ~alu_res_q;
    assign alu_flags = alu_flg(alu_res_q, alu_a, alu_b, alu_op);

    typedef struct {
        int         port;
        logic [7:0] data;
        logic [3:0] flags;
        int         acc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        int         gap;
    } op_t;

    exp_t sbq[$];
    op_t  pq0[$];
    op_t  pq1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   exp_last, bp_left, last_acc;
    bit   mon_en, rnd_rdy, chk_thru;
    exp_t m_e;
    int   m_ph;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response-side monitor: phase relative to the accept cycle of the oldest op.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else if (mon_en) begin
            if (sbq.size() == 0 || (cyc - sbq[0].acc) < 1) begin
                chk("idle_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
                chk("idle_alu_en", 32'(alu_en_out), 32'd0);
            end else begin
                m_e  = sbq[0];
                m_ph = cyc - m_e.acc;
                chk("hold_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
                chk("busy", 32'(busy), 32'd1);
                if (m_ph < 3) begin
                    chk("alu_en", 32'(alu_en_out), 32'(m_ph == 2));
                    chk("early_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
                end else begin
                    chk("rsp_valid", 32'({rsp1_valid, rsp0_valid}), (m_e.port == 1) ? 32'd2 : 32'd1);
                    chk("alu_en_resp", 32'(alu_en_out), 32'd0);
                    chk("rsp_data", 32'(rsp_data), 32'(m_e.data));
                    chk("rsp_flags", 32'(rsp_flags), 32'(m_e.flags));
                    if ((m_e.port == 1) ? rsp1_ready : rsp0_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic add_op(input int port, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int gap);
        op_t o;
        o.a = a; o.b = b; o.op = op; o.gap = gap;
        if (port == 1) pq1.push_back(o);
        else           pq0.push_back(o);
    endtask

    // Called and returns at #1 after a rising edge.
    task automatic run(input int budget);
        int   n, gap0, gap1, p, w;
        logic g_rdy;
        exp_t e;
        op_t  o;
        n        = 0;
        gap0     = (pq0.size() != 0) ? pq0[0].gap : 0;
        gap1     = (pq1.size() != 0) ? pq1[0].gap : 0;
        last_acc = -1;
        while ((pq0.size() != 0 || pq1.size() != 0 || sbq.size() != 0) && n < budget) begin
            if (pq0.size() != 0 && gap0 == 0) begin
                req0_valid = 1'b1; req0_a = pq0[0].a; req0_b = pq0[0].b; req0_op = pq0[0].op;
            end else begin
                req0_valid = 1'b0;
                if (gap0 > 0) gap0--;
            end
            if (pq1.size() != 0 && gap1 == 0) begin
                req1_valid = 1'b1; req1_a = pq1[0].a; req1_b = pq1[0].b; req1_op = pq1[0].op;
            end else begin
                req1_valid = 1'b0;
                if (gap1 > 0) gap1--;
            end
            g_rdy = (bp_left == 0) && (!rnd_rdy || $urandom_range(0, 1) == 1);
            if ((rsp0_valid || rsp1_valid) && bp_left > 0) bp_left--;
            if (sbq.size() != 0 && sbq[0].port == 1) begin
                rsp1_ready = g_rdy; rsp0_ready = 1'($urandom_range(0, 1));
            end else if (sbq.size() != 0) begin
                rsp0_ready = g_rdy; rsp1_ready = 1'($urandom_range(0, 1));
            end else begin
                rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("single_grant", 32'(req0_ready & req1_ready), 32'd0);
            if (req0_ready ^ req1_ready) begin
                p = req1_ready ? 1 : 0;
                w = (req0_valid && req1_valid) ? ((exp_last == 1) ? 0 : 1) : (req1_valid ? 1 : 0);
                chk("grant_port", 32'(p), 32'(w));
                chk("ready_needs_valid", 32'((p == 1) ? req1_valid : req0_valid), 32'd1);
                if (chk_thru && last_acc >= 0) chk("throughput", 32'(cyc - last_acc), 32'd4);
                last_acc = cyc;
                o = '{a: 8'h00, b: 8'h00, op: 3'b000, gap: 0};
                if (p == 1 && pq1.size() != 0) begin
                    o = pq1.pop_front();
                    gap1 = (pq1.size() != 0) ? pq1[0].gap : 0;
                end else if (p == 0 && pq0.size() != 0) begin
                    o = pq0.pop_front();
                    gap0 = (pq0.size() != 0) ? pq0[0].gap : 0;
                end
                e.port  = p;
                e.data  = alu_res(o.a, o.b, o.op);
                e.flags = alu_flg(e.data, o.a, o.b, o.op);
                e.acc   = cyc;
                sbq.push_back(e);
                exp_last = p;
            end
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) chk("run_timeout", 32'(pq0.size() + pq1.size() + sbq.size()), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        pq0.delete();
        pq1.delete();
    endtask

    initial begin
        int   k;
        exp_t e;
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        mon_en = 1'b0; rnd_rdy = 1'b0; chk_thru = 1'b0;
        bp_left = 0; exp_last = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_en", 32'(alu_en_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Both ports valid from reset: grants alternate starting with port 0.
        for (int i = 0; i < 3; i++) begin
            add_op(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
            add_op(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
        end
        chk_thru = 1'b1;
        run(100);
        chk_thru = 1'b0;

        add_op(0, OP_ADD, 8'h7F, 8'h01, 0); run(50);
        add_op(1, OP_SUB, 8'h00, 8'h01, 0); run(50);
        add_op(0, OP_CMP, 8'h42, 8'h42, 0); run(50);
        add_op(1, OP_SHR, 8'h03, 8'h00, 0); run(50);

        // Back-pressure on the first response while the other port waits.
        bp_left = 5;
        add_op(0, OP_ADD, 8'hC0, 8'h50, 0);
        add_op(1, OP_SHL, 8'h81, 8'h00, 0);
        run(100);
        bp_left = 0;

        // Leave last grant on port 0, then reset with port 1 in CAPTURE.
        add_op(0, OP_AND, 8'hF0, 8'h3C, 0); run(50);
        req1_valid = 1'b1; req1_a = 8'h7F; req1_b = 8'h7F; req1_op = OP_ADD;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!req1_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_accept", 32'(req1_ready), 32'd1);
        e.port = 1; e.data = 8'hFE; e.flags = 4'b0110; e.acc = cyc;
        sbq.push_back(e);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_capture_en", 32'(alu_en_out), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_last = 1;
        chk("rst_mid_alu_en", 32'(alu_en_out), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("rst_mid_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_mid_alu_a", 32'(alu_a), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        add_op(0, OP_OR, 8'h12, 8'h81, 0);
        add_op(1, OP_NOT, 8'h0F, 8'h00, 0);
        run(50);

        // Random traffic with gaps and random response back-pressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            add_op(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
            add_op(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
        end
        run(2000);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
